bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master fixed-priority bus arbiter with a registered grant FSM.
- Sits directly upstream of the slave address decoder. Its muxed s_address drives the decoder; s_wr and s_din fan out to every slave.
- Master 0 is the testbench/CPU port. Master 1 is the DMAC master port.
- Master 0 is the parked default owner. Master 1 owns the bus while it keeps requesting.

Parameters:
- AW, 8, address width; matches the decoder input s_address[7:0].
- DW, 32, write-data width.
- MAX_HOLD, 16, maximum consecutive M1 ownership cycles before preemption (used only with BUS_PREEMPT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 bus request.
- m0_wr  in  1  master 0 write strobe (1=write, 0=read).
- m0_address  in  AW  master 0 address.
- m0_dout  in  DW  master 0 write data.
- m1_req  in  1  master 1 (DMAC) bus request.
- m1_wr  in  1  master 1 write strobe.
- m1_address  in  AW  master 1 address.
- m1_dout  in  DW  master 1 write data.
- m0_grant  out  1  master 0 owns bus (registered).
- m1_grant  out  1  master 1 owns bus (registered).
- s_address  out  AW  muxed address to the decoder and slaves.
- s_wr  out  1  muxed, gated write strobe to slaves.
- s_din  out  DW  muxed write data to slaves.
- hold_cnt  out  5  consecutive cycles in M1_GRANT, saturating at 31.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates on the rising clk edge.
- Reset values:
  - state = M0_GRANT, so m0_grant=1 and m1_grant=0.
  - hold_cnt=0.
  - s_address=m0_address and s_din=m0_dout (combinational passthrough).
  - s_wr=0 while reset is asserted.
- FSM states: M0_GRANT, M1_GRANT (1-bit encoding). m0_grant=(state==M0_GRANT); m1_grant=(state==M1_GRANT). Exactly one grant is high at all times.
- M0_GRANT transitions:
  - m0_req=0 and m1_req=1 -> M1_GRANT.
  - otherwise stay. This includes m0_req=1 with m1_req=1: M0 has priority and is never preempted.
- M1_GRANT transitions:
  - m1_req=0 -> M0_GRANT.
  - otherwise stay, subject to the Optional Feature.
- Grant latency: a request seen at edge N takes ownership from edge N+1. A master may drive transfers only in cycles where its grant is high.
- Datapath mux (combinational from state):
  - s_address, s_din, and the s_wr source select m0_* in M0_GRANT and m1_* in M1_GRANT.
  - s_wr = selected master's wr AND selected master's req.
  - An idle owner therefore never produces a write. Its address still propagates, so the decoder output is don't-care for reads.
- hold_cnt:
  - cleared to 0 on any cycle where the next state is M0_GRANT.
  - in M1_GRANT with next state M1_GRANT: incremented, saturating at 31 with no wrap.
- Simultaneous first requests from idle (m0_req=m1_req=1): M0 is already parked, so it keeps the bus with zero turnaround.
- Reset mid-transfer: the next edge forces M0_GRANT and hold_cnt=0 regardless of requests. s_wr=0 during reset, so no in-flight write reaches a slave.
- No bubble cycle between owners. The handover edge switches the grant and mux together.

Optional Feature:
- Macro: BUS_PREEMPT_EN.
- Defined: in M1_GRANT, if m0_req=1 and hold_cnt==MAX_HOLD-1, the next state is M0_GRANT (preemption) and hold_cnt clears. M1 must re-request and waits for m0_req=0.
- Undefined: M1 keeps the bus for as long as m1_req=1; m0_req is ignored in M1_GRANT. hold_cnt still counts, for debug and observability.

Decomposition:
- Shared bus package:
  - state encoding constants ST_M0_GRANT=1'b0, ST_M1_GRANT=1'b1.
  - AW/DW default constants, so the decoder and slaves agree on address width.
- One natural sub-module: bus_mux2, a pure 2:1 mux for {address, wr, dout}, selected by state. It is reused for the slave read-data return path.
- FSM and counter stay in the top module.

Test Plan:
- Reset with m1_req=1 held -> m0_grant=1, m1_grant=0, hold_cnt=0, s_wr=0 during reset. m1_grant=1 on the first edge after reset is released with m0_req=0.
- m0_req=0, m1_req=1, m1_wr=1, m1_address=8'h25, m1_dout=32'hA5A5 -> one edge later: m1_grant=1, s_address=8'h25, s_wr=1, s_din=32'hA5A5 (the decoder then selects the multiplier RAM).
- In M0_GRANT, m0_req=m1_req=1 for 10 cycles -> m0_grant stays 1 throughout. Drop m0_req -> m1_grant=1 on the next edge.
- In M1_GRANT, drop m1_req -> m0_grant=1 next edge, hold_cnt=0. With m0_req=0, s_wr=0 even if m0_wr=1.
- BUS_PREEMPT_EN defined, MAX_HOLD=16, m1_req held, m0_req raised -> m0_grant=1 on the edge after hold_cnt reads 15. Without the macro, M1 holds for 40 cycles and hold_cnt saturates at 31.
- Reset asserted mid M1 write burst at address 8'h45 -> s_wr=0 in that cycle, next state M0_GRANT, hold_cnt=0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the two-master arbiter, decoder and slaves.
// Grant state encoding, default bus widths and the hold counter helpers.
package bus_arbiter_pkg;

    localparam int BUS_AW = 8;
    localparam int BUS_DW = 32;
    localparam int HOLD_W = 5;

    localparam logic [HOLD_W-1:0] HOLD_SAT = 5'd31;

    typedef enum logic {
        ST_M0_GRANT = 1'b0,
        ST_M1_GRANT = 1'b1
    } state_t;

    // Saturating increment for the M1 ownership counter.
    function automatic logic [HOLD_W-1:0] hold_inc(
        input logic [HOLD_W-1:0] v
    );
        if (v == HOLD_SAT) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/bus_mux2.sv
// Pure 2:1 selector for an {address, wr, data} bundle.
// Also used on the slave read-data return path, so it holds no state.
module bus_mux2
    import bus_arbiter_pkg::*;
#(
    parameter int AW = BUS_AW,
    parameter int DW = BUS_DW
) (
    input  logic          sel,
    input  logic [AW-1:0] a0_address,
    input  logic          a0_wr,
    input  logic [DW-1:0] a0_dout,
    input  logic [AW-1:0] a1_address,
    input  logic          a1_wr,
    input  logic [DW-1:0] a1_dout,
    output logic [AW-1:0] y_address,
    output logic          y_wr,
    output logic [DW-1:0] y_dout
);

    // Select side 1 when sel is high, side 0 otherwise.
    always_comb begin
        y_address = a0_address;
        y_wr      = a0_wr;
        y_dout    = a0_dout;
        if (sel) begin
            y_address = a1_address;
            y_wr      = a1_wr;
            y_dout    = a1_dout;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master fixed-priority arbiter; master 0 is parked owner.
// Optional M1 preemption after MAX_HOLD cycles under BUS_PREEMPT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int AW       = BUS_AW,
    parameter int DW       = BUS_DW,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_dout,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_dout,
    output logic          m0_grant,
    output logic          m1_grant,
    output logic [AW-1:0] s_address,
    output logic          s_wr,
    output logic [DW-1:0] s_din,
    output logic [4:0]    hold_cnt
);

`ifdef BUS_PREEMPT_EN
    localparam bit PREEMPT_ON = 1'b1;
`else
    localparam bit PREEMPT_ON = 1'b0;
`endif

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              preempt;
    logic              m0_wr_gated;
    logic              m1_wr_gated;
    logic              mux_wr;

    // M0 waiting while M1 has used up its hold window.
    assign preempt = PREEMPT_ON && m0_req && (hold_cnt_q == HOLD_LIMIT);

    // State register; reset parks the bus on master 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_M0_GRANT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: M0 wins ties, M1 keeps the bus while requesting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_M0_GRANT: begin
                if (!m0_req && m1_req) begin
                    state_d = ST_M1_GRANT;
                end
            end
            ST_M1_GRANT: begin
                if (!m1_req || preempt) begin
                    state_d = ST_M0_GRANT;
                end
            end
            default: state_d = ST_M0_GRANT;
        endcase
    end

    // Grant outputs decode straight from the registered state.
    always_comb begin
        m0_grant = (state_q == ST_M0_GRANT);
        m1_grant = (state_q == ST_M1_GRANT);
    end

    // Count consecutive M1 cycles; clear whenever M0 is next owner.
    always_comb begin
        hold_cnt_d = '0;
        if (state_q == ST_M1_GRANT && state_d == ST_M1_GRANT) begin
            hold_cnt_d = hold_inc(hold_cnt_q);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign hold_cnt = hold_cnt_q;

    // An idle owner must never strobe a write.
    always_comb begin
        m0_wr_gated = m0_wr & m0_req;
        m1_wr_gated = m1_wr & m1_req;
    end

    bus_mux2 #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .sel        (state_q == ST_M1_GRANT),
        .a0_address (m0_address),
        .a0_wr      (m0_wr_gated),
        .a0_dout    (m0_dout),
        .a1_address (m1_address),
        .a1_wr      (m1_wr_gated),
        .a1_dout    (m1_dout),
        .y_address  (s_address),
        .y_wr       (mux_wr),
        .y_dout     (s_din)
    );

    // Block any in-flight write while reset is asserted.
    always_comb begin
        s_wr = mux_wr & ~reset;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus random traffic,
// checked every cycle against an owner/hold-count reference model.
module tb_bus_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 16;

`ifdef BUS_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req;
    logic          m0_wr;
    logic [AW-1:0] m0_address;
    logic [DW-1:0] m0_dout;
    logic          m1_req;
    logic          m1_wr;
    logic [AW-1:0] m1_address;
    logic [DW-1:0] m1_dout;
    logic          m0_grant;
    logic          m1_grant;
    logic [AW-1:0] s_address;
    logic          s_wr;
    logic [DW-1:0] s_din;
    logic [4:0]    hold_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int m_owner = 0;
    int m_hold  = 0;

    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          e_wr;

    bus_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_address (m0_address),
        .m0_dout    (m0_dout),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_address (m1_address),
        .m1_dout    (m1_dout),
        .m0_grant   (m0_grant),
        .m1_grant   (m1_grant),
        .s_address  (s_address),
        .s_wr       (s_wr),
        .s_din      (s_din),
        .hold_cnt   (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who owns the bus and how long M1 has held it.
    always @(posedge clk) begin
        if (reset) begin
            m_owner <= 0;
            m_hold  <= 0;
        end else if (m_owner == 0) begin
            if (!m0_req && m1_req) m_owner <= 1;
            m_hold <= 0;
        end else if (!m1_req ||
                     (PREEMPT && m0_req && m_hold == MAX_HOLD - 1)) begin
            m_owner <= 0;
            m_hold  <= 0;
        end else begin
            m_hold <= (m_hold < 31) ? m_hold + 1 : 31;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            e_addr = (m_owner == 1) ? m1_address : m0_address;
            e_din  = (m_owner == 1) ? m1_dout : m0_dout;
            e_wr   = reset ? 1'b0 :
                     (m_owner == 1) ? (m1_wr & m1_req) : (m0_wr & m0_req);
            chk("cyc_m0_grant", m0_grant, (m_owner == 0));
            chk("cyc_m1_grant", m1_grant, (m_owner == 1));
            chk("cyc_hold_cnt", hold_cnt, m_hold);
            chk("cyc_s_address", s_address, e_addr);
            chk("cyc_s_din", s_din, e_din);
            chk("cyc_s_wr", s_wr, e_wr);
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit found;
        reset      = 1'b1;
        m0_req     = 1'b0;
        m0_wr      = 1'b0;
        m0_address = 8'h00;
        m0_dout    = 32'h0;
        m1_req     = 1'b1;
        m1_wr      = 1'b1;
        m1_address = 8'h10;
        m1_dout    = 32'h1111;

        @(posedge clk);
        cmp_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_m0_grant", m0_grant, 1'b1);
            chk("rst_m1_grant", m1_grant, 1'b0);
            chk("rst_hold_cnt", hold_cnt, 5'd0);
            chk("rst_s_wr", s_wr, 1'b0);
            chk("rst_s_address", s_address, 8'h00);
        end

        drive();
        reset = 1'b0;
        settle();
        chk("release_m1_grant", m1_grant, 1'b1);

        drive();
        m1_req = 1'b0;
        settle();
        chk("back_to_m0", m0_grant, 1'b1);

        drive();
        m0_req     = 1'b0;
        m1_req     = 1'b1;
        m1_wr      = 1'b1;
        m1_address = 8'h25;
        m1_dout    = 32'hA5A5;
        settle();
        chk("m1_wr_grant", m1_grant, 1'b1);
        chk("m1_wr_addr", s_address, 8'h25);
        chk("m1_wr_s_wr", s_wr, 1'b1);
        chk("m1_wr_din", s_din, 32'hA5A5);

        drive();
        m1_req     = 1'b0;
        m0_req     = 1'b0;
        m0_wr      = 1'b1;
        m0_address = 8'h33;
        settle();
        chk("drop_m1_m0_grant", m0_grant, 1'b1);
        chk("drop_m1_hold", hold_cnt, 5'd0);
        chk("idle_m0_no_wr", s_wr, 1'b0);
        chk("idle_m0_addr", s_address, 8'h33);

        drive();
        m0_req = 1'b1;
        m1_req = 1'b1;
        m0_wr  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("tie_m0_keeps", m0_grant, 1'b1);
        end
        drive();
        m0_req = 1'b0;
        settle();
        chk("m0_drop_m1_grant", m1_grant, 1'b1);
        chk("m0_drop_hold", hold_cnt, 5'd0);

        drive();
        m0_req = 1'b1;
        if (PREEMPT) begin
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (hold_cnt == 5'd15) found = 1'b1;
            end
            chk("preempt_hold15_seen", found, 1'b1);
            if (found) begin
                settle();
                chk("preempt_m0_grant", m0_grant, 1'b1);
                chk("preempt_hold_clr", hold_cnt, 5'd0);
            end
        end else begin
            repeat (40) @(negedge clk);
            chk("nopreempt_m1_grant", m1_grant, 1'b1);
            chk("nopreempt_hold_sat", hold_cnt, 5'd31);
        end

        drive();
        m0_req = 1'b0;
        m1_req = 1'b0;
        settle();

        drive();
        m1_req     = 1'b1;
        m1_wr      = 1'b1;
        m1_address = 8'h45;
        settle();
        settle();
        chk("burst_m1_grant", m1_grant, 1'b1);
        chk("burst_s_wr", s_wr, 1'b1);
        drive();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_s_wr", s_wr, 1'b0);
        chk("midrst_addr", s_address, 8'h45);
        settle();
        chk("midrst_m0_grant", m0_grant, 1'b1);
        chk("midrst_hold", hold_cnt, 5'd0);
        drive();
        reset = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            drive();
            reset      = ($urandom_range(0, 99) == 0);
            m0_req     = ($urandom_range(0, 3) == 0);
            m1_req     = ($urandom_range(0, 19) != 0);
            m0_wr      = 1'($urandom);
            m1_wr      = 1'($urandom);
            m0_address = 8'($urandom);
            m1_address = 8'($urandom);
            m0_dout    = $urandom;
            m1_dout    = $urandom;
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
